// File: rtl/pipelined_carry_skip_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_carry_skip_adder                                                 |
// | Add/subtract resolved one carry-skip block per stage; skip stats + count.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipelined_carry_skip_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [WIDTH/BLOCK-1:0] skip_mask,
  output logic [CNT_W-1:0]       skip_cnt,
  input  logic                   cnt_clr
);

  localparam int c_NBLK = WIDTH / BLOCK;
  localparam int c_PCW  = $clog2(c_NBLK + 1);

  // Stage k register holds the beat after block k has been resolved.
  logic              r_vld [c_NBLK];
  logic [WIDTH-1:0]  r_a   [c_NBLK-1];
  logic [WIDTH-1:0]  r_b   [c_NBLK-1];
  logic [WIDTH-1:0]  r_sum [c_NBLK];
  logic              r_c   [c_NBLK];
  logic [c_NBLK-1:0] r_p   [c_NBLK];
  logic              r_ovf;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_src_vld [c_NBLK];
  logic [WIDTH-1:0]  w_src_a   [c_NBLK];
  logic [WIDTH-1:0]  w_src_b   [c_NBLK];
  logic [WIDTH-1:0]  w_src_sum [c_NBLK];
  logic              w_src_c   [c_NBLK];
  logic [c_NBLK-1:0] w_src_p   [c_NBLK];
  logic [BLOCK:0]    w_blk     [c_NBLK];
  logic              w_pk      [c_NBLK];
  logic              w_ck      [c_NBLK];
  logic [WIDTH-1:0]  w_nsum    [c_NBLK];
  logic [c_NBLK-1:0] w_np      [c_NBLK];
  logic              w_adv;
  logic              w_fire_out;
  logic              w_cmsb;
  logic [c_PCW-1:0]  w_pop;
  logic [CNT_W:0]    w_cnt_sum;

  always_comb begin
    w_adv      = !r_vld[c_NBLK-1] || out_ready;
    w_fire_out = r_vld[c_NBLK-1] && out_ready;

    w_src_vld[0] = in_valid;
    w_src_a[0]   = a;
    w_src_b[0]   = sub ? ~b : b;
    w_src_sum[0] = '0;
    w_src_c[0]   = sub | cin;
    w_src_p[0]   = '0;
    for (int k = 1; k < c_NBLK; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_sum[k] = r_sum[k-1];
      w_src_c[k]   = r_c[k-1];
      w_src_p[k]   = r_p[k-1];
    end

    for (int k = 0; k < c_NBLK; k++) begin
      w_blk[k] = {1'b0, w_src_a[k][k*BLOCK +: BLOCK]}
               + {1'b0, w_src_b[k][k*BLOCK +: BLOCK]}
               + {{BLOCK{1'b0}}, w_src_c[k]};
      w_pk[k]  = &(w_src_a[k][k*BLOCK +: BLOCK] ^ w_src_b[k][k*BLOCK +: BLOCK]);
      // An all-propagate block passes its carry-in straight through.
      w_ck[k]  = w_pk[k] ? w_src_c[k] : w_blk[k][BLOCK];
      w_nsum[k] = w_src_sum[k];
      w_nsum[k][k*BLOCK +: BLOCK] = w_blk[k][BLOCK-1:0];
      w_np[k] = w_src_p[k];
      w_np[k][k] = w_pk[k];
    end

    w_cmsb = w_src_a[c_NBLK-1][WIDTH-1] ^ w_src_b[c_NBLK-1][WIDTH-1]
           ^ w_blk[c_NBLK-1][BLOCK-1];

    w_pop = '0;
    for (int k = 0; k < c_NBLK; k++) begin
      w_pop = w_pop + c_PCW'(r_p[c_NBLK-1][k]);
    end
    w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < c_NBLK; k++) begin
        r_vld[k] <= 1'b0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_p[k]   <= '0;
      end
      for (int k = 0; k < c_NBLK-1; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < c_NBLK; k++) begin
        r_vld[k] <= w_src_vld[k];
        // Bubbles leave the data registers untouched.
        if (w_src_vld[k]) begin
          r_sum[k] <= w_nsum[k];
          r_c[k]   <= w_ck[k];
          r_p[k]   <= w_np[k];
        end
      end
      for (int k = 0; k < c_NBLK-1; k++) begin
        if (w_src_vld[k]) begin
          r_a[k] <= w_src_a[k];
          r_b[k] <= w_src_b[k];
        end
      end
      if (w_src_vld[c_NBLK-1]) begin
        r_ovf <= w_cmsb ^ w_ck[c_NBLK-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_fire_out) begin
      r_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld[c_NBLK-1];
  assign sum       = r_sum[c_NBLK-1];
  assign cout      = r_c[c_NBLK-1];
  assign ovf       = r_ovf;
  assign skip_mask = r_p[c_NBLK-1];
  assign skip_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_skip_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipelined_carry_skip_adder                                              |
// | Scoreboard bench: arithmetic reference model, decoupled output monitor.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pipelined_carry_skip_adder;

  localparam int c_NBLK    = 4;
  localparam int c_CNT_MAX = 15;
  localparam int c_LAT     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;
  logic [3:0]  skip_mask, skip_cnt;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [3:0]  mask;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_stall = -1;
  int   model_cnt = 0;
  int   rdy_mode = 0;
  int   rpat = 0;
  bit   clr_rand = 1'b0;

  pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf),
    .skip_mask(skip_mask), .skip_cnt(skip_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Reference: plain integer arithmetic, block skip = nibble fully propagates.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic s);
    exp_t        e;
    int unsigned ux, uy, tot;
    int          sx, sy, r;
    logic [3:0]  na, nb;
    ux = x; uy = y;
    sx = $signed(x); sy = $signed(y);
    if (s) begin
      e.sum  = 16'(ux - uy);
      e.cout = (ux >= uy);
      r      = sx - sy;
    end else begin
      tot    = ux + uy + ci;
      e.sum  = 16'(tot);
      e.cout = (tot > 32'hFFFF);
      r      = sx + sy + int'(ci);
    end
    e.ovf = (r > 32767) || (r < -32768);
    for (int k = 0; k < c_NBLK; k++) begin
      na = x[k*4 +: 4];
      nb = y[k*4 +: 4];
      e.mask[k] = s ? (na == nb) : (nb == ~na);
    end
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // out_ready patterns: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       begin out_ready = (rpat % 3 == 0); rpat++; end
      default: out_ready = 1'($urandom);
    endcase
  end

  // Monitor / scoreboard
  logic [15:0] p_sum;
  logic        p_cout, p_ovf, p_stall;
  logic [3:0]  p_mask;
  bit          have_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int   pop;
    #1;
    if (rst) begin
      model_cnt = 0;
      have_prev = 1'b0;
      last_stall = -1;
    end else begin
      chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (have_prev && p_stall) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== p_sum || cout !== p_cout ||
            ovf !== p_ovf || skip_mask !== p_mask) begin
          errors++;
          $display("FAIL hold: got v=%b sum=%h cout=%b ovf=%b mask=%b required sum=%h cout=%b ovf=%b mask=%b",
                   out_valid, sum, cout, ovf, skip_mask, p_sum, p_cout, p_ovf, p_mask);
        end
      end
      chk("skip_cnt", skip_cnt, 32'(model_cnt));
      pop = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: sum=%h with no beat outstanding", sum);
          pop = $countones(skip_mask);
        end else begin
          e = q.pop_front();
          pop = $countones(e.mask);
          checks++;
          if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || skip_mask !== e.mask) begin
            errors++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b mask=%b expected sum=%h cout=%b ovf=%b mask=%b",
                     sum, cout, ovf, skip_mask, e.sum, e.cout, e.ovf, e.mask);
          end
          if (e.acc_cyc > last_stall) chk("latency", 32'(cyc - e.acc_cyc), 32'(c_LAT));
        end
      end
      if (cnt_clr) model_cnt = 0;
      else if (out_valid && out_ready)
        model_cnt = (model_cnt + pop > c_CNT_MAX) ? c_CNT_MAX : model_cnt + pop;
      if (out_valid && !out_ready) last_stall = cyc;
      p_stall = out_valid && !out_ready;
      p_sum = sum; p_cout = cout; p_ovf = ovf; p_mask = skip_mask;
      have_prev = 1'b1;
    end
  end

  // Driver tasks: entered and left at a falling edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic ci, input logic s);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = s;
    cnt_clr = clr_rand && ($urandom_range(0, 15) == 0);
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
      cnt_clr = clr_rand && ($urandom_range(0, 15) == 0);
      #1;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles", in_ready, n);
    end else begin
      e = model(x, y, ci, s);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    cnt_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      cnt_clr = clr_rand && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    cnt_clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 32'(q.size()), 32'd0);
  endtask

  task automatic send_rand();
    logic [15:0] x, y;
    logic        s;
    x = 16'($urandom); y = 16'($urandom); s = 1'($urandom);
    for (int k = 0; k < c_NBLK; k++)
      if ($urandom_range(0, 2) == 0) y[k*4 +: 4] = s ? x[k*4 +: 4] : ~x[k*4 +: 4];
    send(x, y, 1'($urandom), s);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_skip_mask", skip_mask, 0);
    chk("rst_skip_cnt", skip_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed corners
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h0FFF, 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h1234, 16'h1234, 1'b1, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain();

    // Back-to-back stream under a 1,0,0 out_ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_rand();
    drain();
    rdy_mode = 0;

    // Counter saturation then clear coinciding with a handshake
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    drain();
    chk("cnt_saturated", skip_cnt, 15);
    send(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    cnt_clr = 1'b1;
    #1;
    chk("clr_with_handshake", out_valid && out_ready, 1);
    @(negedge clk);
    cnt_clr = 1'b0;
    #2;
    chk("cnt_cleared", skip_cnt, 0);
    @(negedge clk);

    // Reset with three beats in flight
    send(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b1;
    q.delete();
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_skip_cnt", skip_cnt, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    drain();

    // Randomized traffic with random back-pressure and clears
    rdy_mode = 2;
    clr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      send_rand();
    end
    clr_rand = 1'b0;
    rdy_mode = 0;
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_carry_skip_adder.md
# pipelined_carry_skip_adder

Parametrised, pipelined carry-skip adder/subtractor. The operand is split into WIDTH/BLOCK blocks, and each block is resolved in its own pipeline stage. Block-carry uses the skip rule: if every bit of a block propagates, the carry into the block bypasses it. The block sits in the datapath between operand producers and consumers, with a valid/ready handshake on both sides. It also reports per-result skip activity and keeps a running skip-event count for performance characterisation.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK
- BLOCK, 4, bits per skip block; NBLK = WIDTH/BLOCK ≥ 2
- CNT_W, 16, width of the skip-event counter
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat when in_valid && in_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add mode only)
- sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1; cin ignored)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result when out_valid && out_ready
- sum  out  WIDTH  result bits
- cout  out  1  carry out of MSB (in sub mode, 1 = no borrow)
- ovf  out  1  signed (two's-complement) overflow
- skip_mask  out  NBLK  bit k = 1 if block k was all-propagate for this result
- skip_cnt  out  CNT_W  saturating count of skipped blocks over accepted results
- cnt_clr  in  1  synchronous clear of skip_cnt

## Operation
- Input stage: form b_eff = sub ? ~b : b and c0 = sub ? 1 : cin.
- Stage k (k = 0..NBLK-1) processes block k only:
  - Compute the ripple sum of a[k] + b_eff[k] + c_k.
  - Compute P_k = &(a[k] ^ b_eff[k]).
  - Set c_{k+1} = P_k ? c_k : ripple carry-out of block k. This equals the true carry; the skip only changes which path is selected.
- Unprocessed upper operand bits and completed lower sum bits travel with the beat through the pipeline registers.
- Final stage drives:
  - sum (registered).
  - cout = c_NBLK.
  - ovf = carry into MSB XOR c_NBLK.
  - skip_mask = {P_{NBLK-1} .. P_0}.
- Pipeline control is a global stall:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - All stages shift only when adv = 1.
  - A stage register holding no beat carries valid = 0 (bubble). Bubbles advance and are overwritten; there is no compaction.
- skip_cnt:
  - On each output handshake (out_valid && out_ready), add popcount(skip_mask), saturating at 2^CNT_W-1.
  - cnt_clr has priority over the increment; the cleared value is 0 even if a handshake occurs in the same cycle.
- Results emerge strictly in acceptance order, with no drop or duplication.

## Timing
- Latency is NBLK cycles from input handshake to out_valid (4 for defaults), provided out_ready is held high.
- Throughput is one result per cycle with out_ready = 1.
- While out_valid && !out_ready:
  - The pipeline freezes and in_ready = 0.
  - sum, cout, ovf and skip_mask stay stable.
- Reset (asynchronous, any time, including mid-stream):
  - All stage valids = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, skip_mask = 0, skip_cnt = 0.
  - In-flight beats are discarded.
  - in_ready = 1 immediately, since it follows out_valid = 0.
- Output handshake and new input acceptance in the same cycle are legal; both occur.
- cin/sub are sampled only on the input handshake. Changes at other times have no effect.
- Wrap-around:
  - 0xFFFF + 0x0001 (add, cin = 0) → sum = 0x0000, cout = 1.
  - The sum is always taken mod 2^WIDTH.

## Test plan
- Reset, then a = 0x1234, b = 0x1111, cin = 0, sub = 0, out_ready = 1 → out_valid exactly 4 cycles later; sum = 0x2345, cout = 0, ovf = 0, skip_mask = 0b0000.
- a = 0x0FFF, b = 0x0000, cin = 1 → sum = 0x1000, cout = 0, skip_mask = 0b0111, skip_cnt += 3. a = 0xFFFF, b = 0x0000, cin = 1 → sum = 0x0000, cout = 1, skip_mask = 0b1111.
- sub = 1, a = 0x0005, b = 0x0007 → sum = 0xFFFE, cout = 0. sub = 1, a = 0x8000, b = 0x0001 → sum = 0x7FFF, ovf = 1, cout = 1.
- Back-to-back stream of 8 beats with out_ready toggling 1,0,0,1,… → in_ready = 0 during every stall; outputs hold stable; all 8 results arrive in order, none lost or duplicated.
- Assert rst for 1 cycle with 3 beats in flight → out_valid = 0 and skip_cnt = 0 in the same cycle; the next accepted beat emerges after 4 cycles with the correct sum.
- Preload skip_cnt to near saturation (CNT_W = 4; 15 skipped blocks), then a skip_mask = 0b1111 handshake → skip_cnt = 15. Handshake with cnt_clr = 1 in the same cycle → skip_cnt = 0.
